// File: rtl/barrel_pool_if.sv
// barrel_pool_if -- bundle of the barrel pool's control inputs, per-slot
// barrel positions and pool status outputs.
//   master : game logic side (drives run/drop/tick/positions, reads status)
//   slave  : barrel_pool side
// Parameters must match those given to the barrel_pool instance.
interface barrel_pool_if #(
    parameter int N_SLOTS = 16,
    parameter int XW      = 10,
    parameter int YW      = 9
);
    localparam int CW = $clog2(N_SLOTS + 1);
    localparam int IW = $clog2(N_SLOTS);

    logic                  run;
    logic                  drop;
    logic                  tick;
    logic [XW-1:0]         mario_x;
    logic [YW-1:0]         mario_y;
    logic [N_SLOTS*XW-1:0] bar_x;
    logic [N_SLOTS*YW-1:0] bar_y;
    logic [N_SLOTS-1:0]    bar_fall;

    logic [N_SLOTS-1:0]    spawn;
    logic [N_SLOTS-1:0]    retire;
    logic [N_SLOTS-1:0]    active;
    logic [CW-1:0]         active_cnt;
    logic [7:0]            drop_miss;
    logic                  collision;
    logic [IW-1:0]         hit_slot;
    logic                  scan_busy;
    logic                  scan_done;

    modport master (
        output run, drop, tick, mario_x, mario_y, bar_x, bar_y, bar_fall,
        input  spawn, retire, active, active_cnt, drop_miss,
               collision, hit_slot, scan_busy, scan_done
    );

    modport slave (
        input  run, drop, tick, mario_x, mario_y, bar_x, bar_y, bar_fall,
        output spawn, retire, active, active_cnt, drop_miss,
               collision, hit_slot, scan_busy, scan_done
    );
endinterface

// File: rtl/barrel_pool.sv
// barrel_pool -- slot allocator and per-frame scanner for rolling/falling
// barrels. A drop claims the lowest free slot; a tick starts a scan that
// visits one slot per cycle, retiring barrels past the exit corner and
// latching the first barrel that overlaps the player box.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : barrel_pool_if.slave
//          in : run, drop, tick, mario_x/y, bar_x/y/fall (slot i at [i*W +: W])
//          out: spawn, retire (one-hot pulses), active mask, active_cnt,
//               drop_miss (saturating), collision/hit_slot (sticky),
//               scan_busy, scan_done (pulse)
module barrel_pool #(
    parameter int N_SLOTS = 16,
    parameter int XW      = 10,
    parameter int YW      = 9,
    parameter int EXIT_X  = 560,
    parameter int EXIT_Y  = 410,
    parameter int MARIO_W = 34,
    parameter int MARIO_H = 36,
    parameter int ROLL_W  = 32,
    parameter int FALL_W  = 42,
    parameter int BAR_H   = 24
) (
    input  logic          clk,
    input  logic          rst,
    barrel_pool_if.slave  bus
);
    localparam int CW = $clog2(N_SLOTS + 1);
    localparam int IW = $clog2(N_SLOTS);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state, state_nxt;
    logic [IW-1:0]      idx;
    logic               last_slot;
    logic               eval_en;
    logic               scan_busy;

    logic [N_SLOTS-1:0] active_q, spawn_q, retire_q;
    logic [CW-1:0]      cnt_q;
    logic [7:0]         miss_q;
    logic               coll_q;
    logic [IW-1:0]      hit_q;
    logic               done_q;

    // Currently scanned slot
    logic [XW-1:0]      cur_x;
    logic [YW-1:0]      cur_y;
    logic               cur_fall;
    logic               cur_act;
    logic               at_exit;
    logic               overlap;
    logic               do_retire;
    logic               do_hit;

    // Allocation
    logic [N_SLOTS-1:0] alloc_mask;
    logic               found;
    logic               do_spawn;
    logic               do_miss;
    logic [N_SLOTS-1:0] retire_mask;
    logic [N_SLOTS-1:0] active_nxt;
    logic [CW-1:0]      cnt_nxt;

    assign last_slot = (idx == IW'(N_SLOTS - 1));

    // ---------------- scan FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.run && bus.tick) state_nxt = SCAN;
            SCAN:    if (!bus.run || last_slot) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        scan_busy = (state == SCAN);
        eval_en   = (state == SCAN) && bus.run;
    end

    // ---------------- slot evaluation ----------------
    always_comb begin
        logic [XW:0] bx, mx, bw;
        logic [YW:0] by, my;
        cur_x    = bus.bar_x[idx*XW +: XW];
        cur_y    = bus.bar_y[idx*YW +: YW];
        cur_fall = bus.bar_fall[idx];
        cur_act  = active_q[idx];
        // One extra bit so the edge sums never wrap
        bx = {1'b0, cur_x};
        mx = {1'b0, bus.mario_x};
        by = {1'b0, cur_y};
        my = {1'b0, bus.mario_y};
        bw = cur_fall ? (XW+1)'(FALL_W) : (XW+1)'(ROLL_W);
        overlap = (bx < mx + (XW+1)'(MARIO_W)) && (bx + bw > mx) &&
                  (by < my + (YW+1)'(MARIO_H)) && (by + (YW+1)'(BAR_H) > my);
        at_exit = (cur_x > XW'(EXIT_X)) && (cur_y > YW'(EXIT_Y));
        do_retire = eval_en && cur_act && at_exit;
        // A barrel leaving the field this evaluation never counts as a hit
        do_hit    = eval_en && cur_act && !at_exit && overlap;
    end

    // ---------------- allocation ----------------
    always_comb begin
        alloc_mask = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (!found && !active_q[i]) begin
                alloc_mask[i] = 1'b1;
                found         = 1'b1;
            end
        end
        do_spawn = bus.run && bus.drop && found;
        do_miss  = bus.run && bus.drop && !found;
        retire_mask = do_retire ? (N_SLOTS'(1) << idx) : '0;
        // Allocation sees the registered mask, so the spawned slot is always
        // clear and disjoint from the slot being retired.
        active_nxt = (active_q & ~retire_mask) | (do_spawn ? alloc_mask : '0);
        cnt_nxt = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++)
            cnt_nxt = cnt_nxt + CW'(active_nxt[i]);
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            active_q <= '0;
            spawn_q  <= '0;
            retire_q <= '0;
            cnt_q    <= '0;
            miss_q   <= '0;
            coll_q   <= 1'b0;
            hit_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            if (state == IDLE) idx <= '0;
            else if (eval_en)  idx <= idx + 1'b1;
            active_q <= active_nxt;
            spawn_q  <= do_spawn ? alloc_mask : '0;
            retire_q <= retire_mask;
            cnt_q    <= cnt_nxt;
            if (do_miss && miss_q != 8'hFF) miss_q <= miss_q + 8'd1;
            if (do_hit && !coll_q) begin
                coll_q <= 1'b1;
                hit_q  <= idx;
            end
            done_q <= eval_en && last_slot;
        end
    end

    assign bus.spawn      = spawn_q;
    assign bus.retire     = retire_q;
    assign bus.active     = active_q;
    assign bus.active_cnt = cnt_q;
    assign bus.drop_miss  = miss_q;
    assign bus.collision  = coll_q;
    assign bus.hit_slot   = hit_q;
    assign bus.scan_busy  = scan_busy;
    assign bus.scan_done  = done_q;
endmodule

// File: tb/tb_barrel_pool.sv
// tb_barrel_pool -- directed bench for barrel_pool with a 4-slot pool.
module tb_barrel_pool;
    localparam int N  = 4;
    localparam int XW = 10;
    localparam int YW = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    barrel_pool_if #(.N_SLOTS(N), .XW(XW), .YW(YW)) bus ();

    barrel_pool #(.N_SLOTS(N), .XW(XW), .YW(YW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_bar(input int k, input int x, input int y, input logic f);
        bus.bar_x[k*XW +: XW] = XW'(x);
        bus.bar_y[k*YW +: YW] = YW'(y);
        bus.bar_fall[k]       = f;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            bus.drop = 1'b1; cyc();
            bus.drop = 1'b0; cyc();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_active"},  bus.active, 0);
        chk({tag, "_spawn"},   bus.spawn, 0);
        chk({tag, "_retire"},  bus.retire, 0);
        chk({tag, "_coll"},    bus.collision, 0);
        chk({tag, "_hit"},     bus.hit_slot, 0);
        chk({tag, "_miss"},    bus.drop_miss, 0);
        chk({tag, "_cnt"},     bus.active_cnt, 0);
        chk({tag, "_busy"},    bus.scan_busy, 0);
        chk({tag, "_done"},    bus.scan_done, 0);
    endtask

    initial begin
        bus.run = 1'b0; bus.drop = 1'b0; bus.tick = 1'b0;
        bus.mario_x = XW'(100); bus.mario_y = YW'(100);
        for (int k = 0; k < N; k++) set_bar(k, 400, 300, 1'b0);
        cyc(); cyc();
        rst = 1'b0;
        chk_all_zero("reset");

        // Allocation: four drops fill slots in index order, fifth misses
        bus.run = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.drop = 1'b1; cyc();
            bus.drop = 1'b0;
            chk($sformatf("spawn%0d", i), bus.spawn, 32'(1 << i));
            chk($sformatf("cnt%0d", i), bus.active_cnt, i + 1);
            cyc();
            chk($sformatf("spawn_end%0d", i), bus.spawn, 0);
        end
        bus.drop = 1'b1; cyc(); bus.drop = 1'b0;
        chk("full_spawn", bus.spawn, 0);
        chk("full_miss", bus.drop_miss, 1);
        chk("full_cnt", bus.active_cnt, 4);
        chk("full_active", bus.active, 4'hF);

        // Retirement: strict thresholds on both axes
        set_bar(2, 561, 411, 1'b0);
        set_bar(3, 560, 411, 1'b0);
        bus.tick = 1'b1; cyc(); bus.tick = 1'b0;       // edge t
        chk("scan_busy", bus.scan_busy, 1);
        cyc(); cyc(); cyc();                             // t+3
        chk("retire2", bus.retire, 4'b0100);
        chk("retire2_active", bus.active, 4'b1011);
        chk("retire2_cnt", bus.active_cnt, 3);
        cyc();                                           // t+4
        chk("retire_end", bus.retire, 0);
        chk("done_t4", bus.scan_done, 1);
        chk("busy_t4", bus.scan_busy, 0);
        chk("no_retire_560", bus.active, 4'b1011);
        chk("no_coll", bus.collision, 0);
        cyc();
        chk("done_pulse", bus.scan_done, 0);

        // Rolling barrel just clear of mario; a second tick mid-scan is ignored
        set_bar(1, 134, 120, 1'b0);
        bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
        cyc();
        bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
        cyc(); cyc();
        chk("retick_done", bus.scan_done, 1);
        cyc();
        chk("retick_no_restart", bus.scan_busy, 0);
        chk("roll134_nohit", bus.collision, 0);

        // Rolling barrel touching by one pixel
        set_bar(1, 133, 120, 1'b0);
        bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
        repeat (4) cyc();
        chk("roll133_coll", bus.collision, 1);
        chk("roll133_slot", bus.hit_slot, 1);

        // Fresh pool: falling barrel reaches mario, slot 3 also hits
        rst = 1'b1; cyc(); rst = 1'b0;
        fill(4);
        set_bar(1, 60, 120, 1'b1);
        set_bar(3, 100, 100, 1'b0);
        bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
        repeat (4) cyc();
        chk("fall_coll", bus.collision, 1);
        chk("first_hit_slot", bus.hit_slot, 1);
        set_bar(0, 100, 100, 1'b0);
        bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
        repeat (4) cyc();
        chk("hit_slot_sticky", bus.hit_slot, 1);

        // Reset mid-scan with collision set
        bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
        cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        chk_all_zero("midrst");
        for (int k = 0; k < N; k++) set_bar(k, 400, 300, 1'b0);
        fill(1);
        set_bar(0, 561, 411, 1'b0);
        bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
        cyc();
        chk("rescan_slot0", bus.retire, 4'b0001);
        cyc(); cyc(); cyc();
        chk("rescan_done", bus.scan_done, 1);

        // Slot freed this cycle is not allocatable until the next
        fill(4);
        chk("refill_active", bus.active, 4'hF);
        bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
        bus.drop = 1'b1; cyc();
        chk("same_cyc_retire", bus.retire, 4'b0001);
        chk("same_cyc_spawn", bus.spawn, 0);
        chk("same_cyc_miss", bus.drop_miss, 1);
        chk("same_cyc_active", bus.active, 4'b1110);
        cyc(); bus.drop = 1'b0;
        chk("next_cyc_spawn", bus.spawn, 4'b0001);
        chk("next_cyc_active", bus.active, 4'hF);
        set_bar(0, 400, 300, 1'b0);
        repeat (4) cyc();

        // run=0: drops ignored, scan aborts without done
        bus.run = 1'b0;
        bus.drop = 1'b1; cyc(); bus.drop = 1'b0;
        chk("norun_spawn", bus.spawn, 0);
        chk("norun_miss", bus.drop_miss, 1);
        bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
        chk("norun_tick", bus.scan_busy, 0);
        bus.run = 1'b1;
        bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
        cyc();
        bus.run = 1'b0; cyc();
        chk("abort_busy", bus.scan_busy, 0);
        chk("abort_done", bus.scan_done, 0);
        cyc(); cyc();
        chk("abort_no_done", bus.scan_done, 0);

        // drop_miss saturates
        bus.run = 1'b1;
        bus.drop = 1'b1;
        repeat (300) cyc();
        bus.drop = 1'b0;
        chk("miss_sat", bus.drop_miss, 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
